// File: rtl/nn_layer_serial.sv
// Fully-connected layer: NN neurons with loadable weights/bias accumulate a serial
// input frame in lock-step, then saturate, activate and emit results one per beat.
module nn_layer_serial #(
   parameter int    NN             = 10,
   parameter int    numWeight      = 30,
   parameter int    dataWidth      = 16,
   parameter int    weightIntWidth = 4,
   parameter int    layerNum       = 3,
   parameter string actType        = "relu"
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 weightValid,
   input  logic                                 biasValid,
   input  logic [31:0]                          weightVal,
   input  logic [31:0]                          biasVal,
   input  logic [31:0]                          config_layer_num,
   input  logic [31:0]                          config_neuron_num,
   input  logic                                 x_valid,
   input  logic [dataWidth-1:0]                 x_in,
   output logic                                 x_ready,
   output logic                                 o_valid,
   input  logic                                 o_ready,
   output logic [dataWidth-1:0]                 x_out,
   output logic [((NN>1)?$clog2(NN):1)-1:0]     o_idx,
   output logic                                 o_last
);

   localparam int DW = dataWidth;
   localparam int F  = dataWidth - weightIntWidth;
   localparam int AW = 2 * dataWidth;
   localparam int IW = (NN > 1) ? $clog2(NN) : 1;
   localparam int CW = $clog2(numWeight);
   localparam bit RELU = (actType == "relu");

   localparam logic [2:0] ST_ACCUM  = 3'd0;
   localparam logic [2:0] ST_FLUSH  = 3'd1;
   localparam logic [2:0] ST_BIAS   = 3'd2;
   localparam logic [2:0] ST_ACT    = 3'd3;
   localparam logic [2:0] ST_SERIAL = 3'd4;

   logic signed [DW-1:0] w_q    [NN][numWeight];
   logic signed [DW-1:0] w_d    [NN][numWeight];
   logic signed [DW-1:0] b_q    [NN];
   logic signed [DW-1:0] b_d    [NN];
   logic        [CW-1:0] wptr_q [NN];
   logic        [CW-1:0] wptr_d [NN];
   logic signed [AW-1:0] prod_q [NN];
   logic signed [AW-1:0] prod_d [NN];
   logic signed [AW-1:0] acc_q  [NN];
   logic signed [AW-1:0] acc_d  [NN];
   logic signed [DW-1:0] res_q  [NN];
   logic signed [DW-1:0] res_d  [NN];

   logic [2:0]    state_q, state_d;
   logic [CW-1:0] rd_cnt_q, rd_cnt_d;
   logic [IW-1:0] idx_q, idx_d;
   logic          prod_v_q, prod_v_d;
   logic          rdy_q, rdy_d;
   logic signed [DW-1:0] xs;
   logic          unused_hi;

   assign xs        = x_in;
   assign unused_hi = ^{weightVal[31:DW], biasVal[31:DW]};

   function automatic logic signed [AW-1:0] sat_add(input logic signed [AW-1:0] a,
                                                    input logic signed [AW-1:0] b);
      logic [AW:0] s;
      s = {a[AW-1], a} + {b[AW-1], b};
      if (s[AW] != s[AW-1])
         sat_add = s[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
      else
         sat_add = s[AW-1:0];
   endfunction

   // Take the Q(weightIntWidth).F window of the accumulator, clamping if the dropped
   // integer bits are not pure sign extension.
   function automatic logic signed [DW-1:0] activate(input logic signed [AW-1:0] a);
      logic signed [DW-1:0] r;
      r = a[F+DW-1:F];
      if (a[AW-1:F+DW-1] != {(AW-F-DW+1){a[F+DW-1]}})
         r = a[AW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
      if (RELU && r[DW-1])
         r = '0;
      return r;
   endfunction

   always_comb begin
      w_d    = w_q;
      b_d    = b_q;
      wptr_d = wptr_q;
      for (int n = 0; n < NN; n++) begin
         if (config_layer_num == 32'(layerNum) && config_neuron_num == 32'(n)) begin
            if (weightValid) begin
               w_d[n][wptr_q[n]] = weightVal[DW-1:0];
               wptr_d[n] = (wptr_q[n] == CW'(numWeight-1)) ? '0 : wptr_q[n] + CW'(1);
            end
            if (biasValid)
               b_d[n] = biasVal[DW-1:0];
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      rd_cnt_d = rd_cnt_q;
      idx_d    = idx_q;
      prod_v_d = prod_v_q;
      prod_d   = prod_q;
      acc_d    = acc_q;
      res_d    = res_q;
      case (state_q)
         ST_ACCUM: begin
            prod_v_d = x_valid;
            for (int n = 0; n < NN; n++) begin
               if (prod_v_q)
                  acc_d[n] = sat_add(acc_q[n], prod_q[n]);
               if (x_valid)
                  prod_d[n] = AW'(xs) * AW'(w_q[n][rd_cnt_q]);
            end
            if (x_valid) begin
               if (rd_cnt_q == CW'(numWeight-1)) begin
                  rd_cnt_d = '0;
                  state_d  = ST_FLUSH;
               end else begin
                  rd_cnt_d = rd_cnt_q + CW'(1);
               end
            end
         end
         ST_FLUSH: begin
            for (int n = 0; n < NN; n++)
               if (prod_v_q)
                  acc_d[n] = sat_add(acc_q[n], prod_q[n]);
            prod_v_d = 1'b0;
            state_d  = ST_BIAS;
         end
         ST_BIAS: begin
            for (int n = 0; n < NN; n++)
               acc_d[n] = sat_add(acc_q[n], AW'(b_q[n]) <<< F);
            state_d = ST_ACT;
         end
         ST_ACT: begin
            for (int n = 0; n < NN; n++) begin
               res_d[n] = activate(acc_q[n]);
               acc_d[n] = '0;
            end
            idx_d   = '0;
            state_d = ST_SERIAL;
         end
         ST_SERIAL: begin
            if (o_ready) begin
               if (idx_q == IW'(NN-1)) begin
                  idx_d   = '0;
                  state_d = ST_ACCUM;
               end else begin
                  idx_d = idx_q + IW'(1);
               end
            end
         end
         default: state_d = ST_ACCUM;
      endcase
      rdy_d = (state_d == ST_ACCUM);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_ACCUM;
         rd_cnt_q <= '0;
         idx_q    <= '0;
         prod_v_q <= 1'b0;
         rdy_q    <= 1'b0;
         wptr_q   <= '{default: '0};
         acc_q    <= '{default: '0};
      end else begin
         state_q  <= state_d;
         rd_cnt_q <= rd_cnt_d;
         idx_q    <= idx_d;
         prod_v_q <= prod_v_d;
         rdy_q    <= rdy_d;
         wptr_q   <= wptr_d;
         acc_q    <= acc_d;
      end
   end

   // Storage and datapath registers carry no reset; outputs are gated by o_valid.
   always_ff @(posedge clk) begin
      w_q    <= w_d;
      b_q    <= b_d;
      prod_q <= prod_d;
      res_q  <= res_d;
   end

   assign x_ready = rdy_q;
   assign o_valid = (state_q == ST_SERIAL);
   assign x_out   = o_valid ? res_q[idx_q] : '0;
   assign o_idx   = idx_q;
   assign o_last  = o_valid && (idx_q == IW'(NN-1));

endmodule

// File: tb/tb_nn_layer_serial.sv
// Scoreboarded bench for nn_layer_serial: a relu and a linear instance share stimulus,
// expected beats are queued per instance and checked by a monitor on the falling edge.
module tb_nn_layer_serial;

   logic        clk = 1'b0;
   logic        rst;
   logic        weightValid, biasValid;
   logic [31:0] weightVal, biasVal, config_layer_num, config_neuron_num;
   logic        x_valid;
   logic [15:0] x_in;
   logic        o_ready;

   logic        r_x_ready, r_o_valid, r_o_last;
   logic [15:0] r_x_out;
   logic [0:0]  r_o_idx;
   logic        l_x_ready, l_o_valid, l_o_last;
   logic [15:0] l_x_out;
   logic [0:0]  l_o_idx;

   typedef struct packed {
      logic [15:0] d;
      logic        idx;
      logic        last;
   } exp_t;

   exp_t q_r[$];
   exp_t q_l[$];
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   nn_layer_serial #(.NN(2), .numWeight(3), .dataWidth(16), .weightIntWidth(4),
                     .layerNum(3), .actType("relu")) dut_r (
      .clk(clk), .rst(rst), .weightValid(weightValid), .biasValid(biasValid),
      .weightVal(weightVal), .biasVal(biasVal), .config_layer_num(config_layer_num),
      .config_neuron_num(config_neuron_num), .x_valid(x_valid), .x_in(x_in),
      .x_ready(r_x_ready), .o_valid(r_o_valid), .o_ready(o_ready), .x_out(r_x_out),
      .o_idx(r_o_idx), .o_last(r_o_last));

   nn_layer_serial #(.NN(2), .numWeight(3), .dataWidth(16), .weightIntWidth(4),
                     .layerNum(3), .actType("linear")) dut_l (
      .clk(clk), .rst(rst), .weightValid(weightValid), .biasValid(biasValid),
      .weightVal(weightVal), .biasVal(biasVal), .config_layer_num(config_layer_num),
      .config_neuron_num(config_neuron_num), .x_valid(x_valid), .x_in(x_in),
      .x_ready(l_x_ready), .o_valid(l_o_valid), .o_ready(o_ready), .x_out(l_x_out),
      .o_idx(l_o_idx), .o_last(l_o_last));

   task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] req);
      total++;
      if (actual !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, actual, req);
      end
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (!rst) begin
         if (r_o_valid && o_ready) begin
            if (q_r.size() == 0) chk("relu_unexpected_beat", 1, 0);
            else begin
               e = q_r.pop_front();
               chk("relu_x_out", {16'h0, r_x_out}, {16'h0, e.d});
               chk("relu_o_idx", {31'h0, r_o_idx}, {31'h0, e.idx});
               chk("relu_o_last", {31'h0, r_o_last}, {31'h0, e.last});
            end
         end
         if (l_o_valid && o_ready) begin
            if (q_l.size() == 0) chk("lin_unexpected_beat", 1, 0);
            else begin
               e = q_l.pop_front();
               chk("lin_x_out", {16'h0, l_x_out}, {16'h0, e.d});
               chk("lin_o_idx", {31'h0, l_o_idx}, {31'h0, e.idx});
               chk("lin_o_last", {31'h0, l_o_last}, {31'h0, e.last});
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg(input int layer, input int neuron, input bit wv, input bit bv,
                      input logic [15:0] wval, input logic [15:0] bval);
      weightValid       = wv;
      biasValid         = bv;
      weightVal         = {16'hA5A5, wval};
      biasVal           = {16'h5A5A, bval};
      config_layer_num  = 32'(layer);
      config_neuron_num = 32'(neuron);
      tick();
      weightValid = 1'b0;
      biasValid   = 1'b0;
   endtask

   task automatic load(input int n, input logic [15:0] w0, input logic [15:0] w1,
                       input logic [15:0] w2, input logic [15:0] b);
      cfg(3, n, 1, 0, w0, 16'h0);
      cfg(3, n, 1, 0, w1, 16'h0);
      cfg(3, n, 1, 0, w2, 16'h0);
      cfg(3, n, 0, 1, 16'h0, b);
   endtask

   task automatic wait_ready();
      int k = 0;
      while (!r_x_ready && k < 200) begin
         tick();
         k++;
      end
      if (!r_x_ready) chk("x_ready_timeout", 0, 1);
   endtask

   task automatic wait_drain();
      int k = 0;
      while ((q_r.size() != 0 || q_l.size() != 0 || !r_x_ready) && k < 200) begin
         tick();
         k++;
      end
      if (k >= 200) chk("drain_timeout", 0, 1);
   endtask

   // Issues one 3-beat frame; returns one cycle after the last beat is accepted (T+1).
   task automatic frame(input logic [15:0] x0, input logic [15:0] x1, input logic [15:0] x2,
                        input bit push, input logic [15:0] r0, input logic [15:0] r1,
                        input logic [15:0] l0, input logic [15:0] l1);
      wait_ready();
      if (push) begin
         q_r.push_back('{r0, 1'b0, 1'b0});
         q_r.push_back('{r1, 1'b1, 1'b1});
         q_l.push_back('{l0, 1'b0, 1'b0});
         q_l.push_back('{l1, 1'b1, 1'b1});
      end
      x_valid = 1'b1;
      x_in    = x0;
      tick();
      x_in = x1;
      tick();
      x_in = x2;
      tick();
      x_valid = 1'b0;
      x_in    = 16'h0;
   endtask

   initial begin
      rst = 1'b1;
      weightValid = 1'b0; biasValid = 1'b0;
      weightVal = '0; biasVal = '0; config_layer_num = '0; config_neuron_num = '0;
      x_valid = 1'b0; x_in = '0; o_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_x_ready", {31'h0, r_x_ready}, 0);
      chk("reset_o_valid", {31'h0, r_o_valid}, 0);
      chk("reset_x_out", {16'h0, r_x_out}, 0);
      chk("reset_o_idx", {31'h0, r_o_idx}, 0);
      chk("reset_o_last", {31'h0, r_o_last}, 0);
      chk("reset_lin_x_ready", {31'h0, l_x_ready}, 0);
      rst = 1'b0;
      tick();
      chk("post_reset_x_ready", {31'h0, r_x_ready}, 1);

      // Basic frame: 0.75+0.5 and 1.5, with latency and drain timing
      load(0, 16'h1000, 16'h1000, 16'h1000, 16'h0800);
      load(1, 16'h2000, 16'h2000, 16'h2000, 16'h0000);
      frame(16'h0400, 16'h0400, 16'h0400, 1, 16'h1400, 16'h1800, 16'h1400, 16'h1800);
      chk("lat_flush_o_valid", {31'h0, r_o_valid}, 0);
      tick();
      chk("lat_bias_o_valid", {31'h0, r_o_valid}, 0);
      tick();
      chk("lat_act_o_valid", {31'h0, r_o_valid}, 0);
      tick();
      chk("lat_first_o_valid", {31'h0, r_o_valid}, 1);
      chk("lat_first_o_idx", {31'h0, r_o_idx}, 0);
      tick();
      chk("drain_last_o_last", {31'h0, r_o_last}, 1);
      chk("drain_last_x_ready", {31'h0, r_x_ready}, 0);
      tick();
      chk("after_last_x_ready", {31'h0, r_x_ready}, 1);
      chk("after_last_o_valid", {31'h0, r_o_valid}, 0);

      // Negative weight: -3.0 -> relu 0, linear 0xD000; neuron1 6.0
      load(0, 16'hF000, 16'hF000, 16'hF000, 16'h0000);
      frame(16'h1000, 16'h1000, 16'h1000, 1, 16'h0000, 16'h6000, 16'hD000, 16'h6000);
      wait_drain();

      // Positive and negative saturation
      load(0, 16'h7000, 16'h7000, 16'h7000, 16'h7000);
      frame(16'h7000, 16'h7000, 16'h7000, 1, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
      wait_drain();
      load(0, 16'h9000, 16'h9000, 16'h9000, 16'h7000);
      frame(16'h7000, 16'h7000, 16'h7000, 1, 16'h0000, 16'h7FFF, 16'h8000, 16'h7FFF);
      wait_drain();

      // Back-pressure: outputs hold, input pulses during SERIAL are dropped
      load(0, 16'h1000, 16'h1000, 16'h1000, 16'h0000);
      o_ready = 1'b0;
      frame(16'h0400, 16'h0400, 16'h0400, 1, 16'h0C00, 16'h1800, 16'h0C00, 16'h1800);
      tick(); tick(); tick();
      for (int i = 0; i < 5; i++) begin
         chk("stall_o_valid", {31'h0, r_o_valid}, 1);
         chk("stall_x_out", {16'h0, r_x_out}, 32'h0C00);
         chk("stall_o_idx", {31'h0, r_o_idx}, 0);
         chk("stall_lin_x_out", {16'h0, l_x_out}, 32'h0C00);
         x_valid = 1'b1;
         x_in    = 16'h7FFF;
         tick();
      end
      x_valid = 1'b0;
      o_ready = 1'b1;
      wait_drain();
      frame(16'h0400, 16'h0400, 16'h0400, 1, 16'h0C00, 16'h1800, 16'h0C00, 16'h1800);
      wait_drain();

      // Non-matching writes ignored; fourth write wraps to w0[0] with a same-cycle bias write
      cfg(2, 0, 1, 1, 16'h7000, 16'h7000);
      cfg(3, 7, 1, 1, 16'h7000, 16'h7000);
      frame(16'h0400, 16'h0400, 16'h0400, 1, 16'h0C00, 16'h1800, 16'h0C00, 16'h1800);
      wait_drain();
      cfg(3, 0, 1, 0, 16'h2000, 16'h0);
      cfg(3, 0, 1, 0, 16'h1000, 16'h0);
      cfg(3, 0, 1, 0, 16'h1000, 16'h0);
      cfg(3, 0, 1, 1, 16'h3000, 16'h0400);
      frame(16'h0400, 16'h0400, 16'h0400, 1, 16'h1800, 16'h1800, 16'h1800, 16'h1800);
      wait_drain();

      // Reset at T+2 aborts the frame; weights survive
      frame(16'h0400, 16'h0400, 16'h0400, 0, 16'h0, 16'h0, 16'h0, 16'h0);
      tick();
      rst = 1'b1;
      #1;
      chk("rst_mid_o_valid", {31'h0, r_o_valid}, 0);
      chk("rst_mid_x_out", {16'h0, r_x_out}, 0);
      chk("rst_mid_x_ready", {31'h0, r_x_ready}, 0);
      tick();
      rst = 1'b0;
      frame(16'h0400, 16'h0400, 16'h0400, 1, 16'h1800, 16'h1800, 16'h1800, 16'h1800);
      wait_drain();

      // Reset during serialisation drops the pending beats at once
      o_ready = 1'b0;
      frame(16'h0400, 16'h0400, 16'h0400, 0, 16'h0, 16'h0, 16'h0, 16'h0);
      tick(); tick(); tick();
      chk("pre_rst_serial_o_valid", {31'h0, r_o_valid}, 1);
      rst = 1'b1;
      #1;
      chk("rst_serial_o_valid", {31'h0, r_o_valid}, 0);
      chk("rst_serial_x_out", {16'h0, r_x_out}, 0);
      chk("rst_serial_lin_x_out", {16'h0, l_x_out}, 0);
      tick();
      rst = 1'b0;
      o_ready = 1'b1;
      frame(16'h0400, 16'h0400, 16'h0400, 1, 16'h1800, 16'h1800, 16'h1800, 16'h1800);
      wait_drain();

      chk("relu_queue_empty", q_r.size(), 0);
      chk("lin_queue_empty", q_l.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/nn_layer_serial.md
# nn_layer_serial

Parametrised, self-contained fully-connected layer: NN neurons, each with run-time-loadable weight and bias storage, consume a serial input stream in lock-step, then saturate, activate and re-serialise their results one per beat with a valid/ready handshake. It replaces per-neuron hand instantiation with a generated array. It also removes the need for an external parallel-to-serial stage, so layers chain directly.

## Interface
- NN, 10, neuron count (≥1)
- numWeight, 30, inputs per frame = weights per neuron (≥2)
- dataWidth, 16, signed fixed-point width of inputs, weights, bias, outputs
- weightIntWidth, 4, integer bits incl. sign; frac bits F = dataWidth−weightIntWidth
- layerNum, 3, layer id matched against config_layer_num
- actType, "relu", "relu" or "linear"

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- weightValid  in  1  weight write strobe
- biasValid  in  1  bias write strobe
- weightVal  in  32  weight, low dataWidth bits used
- biasVal  in  32  bias, low dataWidth bits used
- config_layer_num  in  32  target layer of a write
- config_neuron_num  in  32  target neuron of a write
- x_valid  in  1  input beat valid
- x_in  in  dataWidth  input beat
- x_ready  out  1  layer accepting input
- o_valid  out  1  output beat valid
- o_ready  in  1  downstream accepts output
- x_out  out  dataWidth  activated neuron result
- o_idx  out  $clog2(NN) (min 1)  neuron index of x_out
- o_last  out  1  beat is neuron NN−1

## Operation
- Config writes (any state):
  - A weightValid with config_layer_num==layerNum and config_neuron_num<NN writes w[n][wptr[n]]. wptr[n] then increments, wrapping numWeight−1→0.
  - A biasValid under the same match writes b[n].
  - Any other write is ignored.
  - Weight and bias storage are not reset. wptr resets to 0.
- States: ACCUM, FLUSH, BIAS, ACT, SERIAL. Reset enters ACCUM with rd_cnt=0, acc=0, prod_v=0.
- ACCUM:
  - x_ready=1. A beat is accepted when x_valid is high.
  - On acceptance, prod[n] ← x_in × w[n][rd_cnt] (signed, 2·dataWidth bits, Q(2·weightIntWidth).(2F)), prod_v←1, and rd_cnt increments.
  - Every cycle with prod_v=1: acc[n] ← sat(acc[n]+prod[n]).
  - Accepting the beat at rd_cnt==numWeight−1 moves to FLUSH and clears rd_cnt.
  - x_valid while x_ready=0 is dropped.
- FLUSH: adds the final product, clears prod_v.
- BIAS: acc[n] ← sat(acc[n] + (sign-extended b[n] << F)).
- ACT:
  - r = acc[n][F+dataWidth−1:F].
  - If acc bits above F+dataWidth−1 are not all equal to r's sign bit, r saturates to 0x7FFF… or 0x8000….
  - relu: negative r → 0. linear: pass r.
  - Result is stored in res[n]. acc[n] clears. Next state is SERIAL with idx=0.
- SERIAL:
  - o_valid=1, x_out=res[idx], o_idx=idx, o_last=(idx==NN−1).
  - On o_ready, idx increments. On the o_last beat, return to ACCUM.
  - Outputs hold stable while o_ready=0.
- Accumulator width is 2·dataWidth. sat() clamps to the signed max/min of that width on overflow.

## Timing
- Reset values: x_ready=0 during reset, 1 in the first cycle after release. o_valid=0, x_out=0, o_idx=0, o_last=0.
- Input throughput is one beat per cycle, with gaps allowed.
- If the last input is accepted in cycle T: FLUSH at T+1, BIAS at T+2, ACT at T+3, first o_valid at T+4.
- Drain takes NN cycles with o_ready held high. x_ready rises the cycle after the o_last handshake.
- Reset mid-frame or mid-serialisation aborts immediately. No partial beat is emitted afterwards, and the next frame starts at rd_cnt=0.
- A weight write during ACCUM takes effect on the next read of that address. Same-cycle read and write of one address reads the old value.
- Simultaneous weightValid and biasValid are both honoured.

## Test plan
Defaults unless stated: NN=2, numWeight=3, dataWidth=16, weightIntWidth=4 (F=12, 1.0=0x1000).
- Load w0={0x1000×3}, b0=0x0800, w1={0x2000×3}, b1=0; input 0x0400×3 back-to-back → beat0 x_out=0x1400 at T+4, beat1 x_out=0x1800 with o_last=1, x_ready=1 the following cycle.
- w0=0xF000 (−1.0) ×3, b0=0, input 0x1000×3, relu → x_out=0x0000; same stimulus with actType="linear" → 0xD000.
- w0=0x7000×3, b0=0x7000, input 0x7000×3 → x_out=0x7FFF; negating w0 → 0x8000 (linear).
- o_ready low for 5 cycles at SERIAL start → o_valid, x_out and o_idx stay constant; x_valid pulses during SERIAL are dropped, and the next frame's result is unaffected.
- Writes with config_layer_num=2, or config_neuron_num=7 → stored weights unchanged. Fourth write to neuron 0 wraps to w0[0].
- Assert rst at T+2 of a frame → o_valid=0 and x_out=0 immediately. Next frame with the same stimulus → identical results, since weights are retained.
